shreg_seq: RTL and testbench
============================

// Module: shreg_seq
// PURPOSE
//  Command sequencer directly upstream of the 4-bit universal shift register (shreg).
//  Accepts one op per valid/ready handshake: NOP, LOAD, SHL/SHR, ROL/ROR or ASR by 0..7.
//  Drives shreg's c, data_in, carry_msb and carry_lsb, one shreg step per clk.
//  Reads shreg data_out back (q_in) for rotate/ASR fill; pulses done when the op completes.
// PARAMETERS
//  W      4  register width; must match shreg (fixed at 4)
//  AMT_W  3  shift-amount width; max amount 2**AMT_W-1
// PORTS
//  clk        in   1      rising-edge clock shared with shreg
//  clr        in   1      reset: asynchronous, active-low; shared with shreg
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept (high only in IDLE)
//  cmd_op     in   3      op code (see BEHAVIOUR)
//  cmd_amt    in   AMT_W  shift/rotate count
//  cmd_data   in   W      LOAD value
//  fill_bit   in   1      bit shifted in on SHL/SHR
//  q_in       in   W      shreg data_out
//  c          out  2      shreg mode select
//  data_in    out  W      shreg parallel load data
//  carry_msb  out  1      bit entering bit3 on right shift
//  carry_lsb  out  1      bit entering bit0 on left shift
//  busy       out  1      op in progress
//  done       out  1      one-cycle completion pulse
// BEHAVIOUR
//  c encoding: 00 HOLD, 01 SHR (bit3<-carry_msb), 10 SHL (bit0<-carry_lsb), 11 LOAD.
//  Ops: 000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 reserved = NOP.
//  Reset (clr=0, async): state IDLE, c=00, data_in=0, cnt=0, busy=0, done=0, cmd_ready=1.
//  FSM: IDLE -> RUN on accept (cmd_valid & cmd_ready at edge E0); op, amt, data latched.
//   RUN: c, data_in registered; cnt counts down one per edge; at the last step edge -> IDLE, c=00, done=1.
//   IDLE: cmd_ready=1, busy=0; done is high for exactly the first IDLE cycle after RUN.
//  Timing: LOAD: c=11 during E0..E1; shreg loads at E1; done high in cycle after E1.
//   Shift/rotate by n>=1: c held for n cycles; shreg steps at E1..En; done high after En.
//   n=0, NOP or reserved: c=00 for one cycle; done high after E1; shreg unchanged.
//  Carries (combinational from latched op and q_in; 0 when not in RUN):
//   SHL: carry_lsb=fill_bit   SHR: carry_msb=fill_bit   ROL: carry_lsb=q_in[3]
//   ROR: carry_msb=q_in[0]    ASR: carry_msb=q_in[3] (sign kept); unused carry=0.
//  Back-to-back: a command may be accepted in the done cycle; the next op starts at that edge.
//  cmd_valid while busy: ignored (cmd_ready=0); inputs need not be held after accept.
//  cmd_amt larger than W is legal: rotates wrap (ROL by 5 == ROL by 1); shifts saturate to all-fill.
//  clr mid-op: immediate abort to reset values; no done pulse; shreg is cleared by the same clr.
// STRUCTURE
//  shreg_pkg: SEL_HOLD/SEL_SHR/SEL_SHL/SEL_LOAD localparams, OP_* codes, FSM state codes.
//  Sub-module shreg_step_cnt: AMT_W loadable down-counter with a last-step flag; FSM and
//  carry mux live in shreg_seq. Top-level test bench instantiates shreg_seq + shreg together.
// TESTING
//  1 clr low mid-ROL by 3 -> outputs at reset values at once, no done, shreg=0000.
//  2 LOAD 1011 -> c=11 one cycle; shreg=1011 at E1; done one cycle later.
//  3 q=1011, ROL amt=1 then ROR amt=2 back-to-back -> 0111, then 1101; two done pulses.
//  4 q=1000, ASR amt=2 -> 1110; q=1000, SHR amt=2 with fill_bit=0 -> 0010.
//  5 q=0110, SHL amt=0 -> c stays 00, q unchanged, done after 1 cycle; op 111 is the same.
//  6 cmd_valid pulsed while busy -> not accepted; ROL amt=5 on 0001 -> 0010 (wrap).

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared encodings for the shreg command sequencer: shreg mode selects, op codes, FSM states.
// Also holds the small helpers that classify op codes.
package shreg_pkg;

    // Mode select driven onto shreg's c input
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    // Command op codes
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
               (op == OP_ROR) || (op == OP_ASR);
    endfunction

    function automatic logic [1:0] op_sel(input logic [2:0] op);
        logic [1:0] sel;
        sel = SEL_HOLD;
        case (op)
            OP_LOAD:                 sel = SEL_LOAD;
            OP_SHL, OP_ROL:          sel = SEL_SHL;
            OP_SHR, OP_ROR, OP_ASR:  sel = SEL_SHR;
            default:                 sel = SEL_HOLD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/shreg_step_cnt.sv
// Loadable down-counter tracking the remaining shreg steps of the current op.
// last is high while exactly one step remains.
module shreg_step_cnt
    import shreg_pkg::*;
#(
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [AMT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [AMT_W-1:0] cnt_q;
    logic [AMT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - AMT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == AMT_W'(1));

endmodule

// File: rtl/shreg_seq.sv
// Command sequencer for the 4-bit universal shift register: turns one accepted op into
// a run of registered shreg mode selects plus the carry bits that feed each step.
module shreg_seq
    import shreg_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [W-1:0]     cmd_data,
    input  logic             fill_bit,
    input  logic [W-1:0]     q_in,
    output logic [1:0]       c,
    output logic [W-1:0]     data_in,
    output logic             carry_msb,
    output logic             carry_lsb,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       c_q, c_d;
    logic [W-1:0]     data_in_q, data_in_d;
    logic             done_q, done_d;

    logic             cnt_load;
    logic [AMT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_last;

    // Only the end bits of the register feed rotate/ASR fill.
    logic             unused_q_mid;
    assign unused_q_mid = ^q_in[W-2:1];

    shreg_step_cnt #(
        .AMT_W(AMT_W)
    ) u_step_cnt (
        .clk     (clk),
        .clr     (clr),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .dec     (cnt_dec),
        .last    (cnt_last)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= StIdle;
            op_q      <= OP_NOP;
            c_q       <= SEL_HOLD;
            data_in_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            c_q       <= c_d;
            data_in_q <= data_in_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        c_d          = c_q;
        data_in_d    = data_in_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = AMT_W'(1);
        cnt_dec      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d  = StRun;
                    op_d     = (cmd_op == OP_RSVD) ? OP_NOP : cmd_op;
                    cnt_load = 1'b1;
                    // Zero-length shifts, NOP and reserved spend one cycle holding.
                    if (is_shift(cmd_op) && (cmd_amt != '0)) begin
                        cnt_load_val = cmd_amt;
                        c_d          = op_sel(cmd_op);
                    end else if (cmd_op == OP_LOAD) begin
                        c_d = SEL_LOAD;
                    end else begin
                        c_d = SEL_HOLD;
                    end
                    data_in_d = (cmd_op == OP_LOAD) ? cmd_data : '0;
                end
            end
            StRun: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d   = StIdle;
                    c_d       = SEL_HOLD;
                    data_in_d = '0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        carry_msb = 1'b0;
        carry_lsb = 1'b0;
        if (state_q == StRun) begin
            case (op_q)
                OP_SHL:  carry_lsb = fill_bit;
                OP_SHR:  carry_msb = fill_bit;
                OP_ROL:  carry_lsb = q_in[W-1];
                OP_ROR:  carry_msb = q_in[0];
                OP_ASR:  carry_msb = q_in[W-1];
                default: begin
                    carry_msb = 1'b0;
                    carry_lsb = 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign c         = c_q;
    assign data_in   = data_in_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shreg_seq.sv
// Bench for shreg_seq driving a behavioural 4-bit shreg; outputs compared each cycle
// against an op-level model of the register contents and handshake timing.
module tb_shreg_seq;

    logic       clk;
    logic       clr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_amt;
    logic [3:0] cmd_data;
    logic       fill_bit;
    logic [3:0] q;
    logic [1:0] c;
    logic [3:0] data_in;
    logic       carry_msb;
    logic       carry_lsb;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic       m_busy;
    logic       m_done;
    int         m_t;
    int         m_len;
    int         m_steps;
    logic [2:0] m_op;
    logic [3:0] m_q0;
    logic [3:0] m_q;
    logic       m_fill;
    logic [3:0] m_data;

    shreg_seq #(
        .W    (4),
        .AMT_W(3)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_amt  (cmd_amt),
        .cmd_data (cmd_data),
        .fill_bit (fill_bit),
        .q_in     (q),
        .c        (c),
        .data_in  (data_in),
        .carry_msb(carry_msb),
        .carry_lsb(carry_lsb),
        .busy     (busy),
        .done     (done)
    );

    // Behavioural shreg sharing clock and reset with the sequencer
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= 4'b0000;
        end else begin
            case (c)
                2'b01:   q <= {carry_msb, q[3:1]};
                2'b10:   q <= {q[2:0], carry_lsb};
                2'b11:   q <= data_in;
                default: q <= q;
            endcase
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register contents after k steps of op on q (LOAD counts one step)
    function automatic logic [3:0] apply(input logic [2:0] op, input logic [3:0] qv, input int k,
                                         input logic f, input logic [3:0] d);
        logic [15:0] t;
        int          r;
        r = k % 4;
        t = 16'h0;
        case (op)
            3'b001: return (k >= 1) ? d : qv;
            3'b010: begin t = {qv, {12{f}}} << k;      return t[15:12]; end
            3'b011: begin t = {{12{f}}, qv} >> k;      return t[3:0];   end
            3'b100: begin t = {8'h00, qv, qv} << r;    return t[7:4];   end
            3'b101: begin t = {8'h00, qv, qv} >> r;    return t[3:0];   end
            3'b110: begin t = {{12{qv[3]}}, qv} >> k;  return t[3:0];   end
            default: return qv;
        endcase
    endfunction

    function automatic logic [1:0] sel_of(input logic [2:0] op);
        case (op)
            3'b001:                 return 2'b11;
            3'b010, 3'b100:         return 2'b10;
            3'b011, 3'b101, 3'b110: return 2'b01;
            default:                return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_t    = 0;
        m_len  = 0;
        m_steps = 0;
        m_op   = 3'b000;
        m_q0   = 4'b0000;
        m_q    = 4'b0000;
        m_fill = 1'b0;
        m_data = 4'b0000;
    endtask

    task automatic compare();
        logic [3:0] exp_q;
        logic [1:0] exp_c;
        int         k;
        k     = (m_t - 1 < m_steps) ? m_t - 1 : m_steps;
        exp_q = m_busy ? apply(m_op, m_q0, k, m_fill, m_data) : m_q;
        exp_c = (m_busy && m_steps > 0) ? sel_of(m_op) : 2'b00;
        chk("busy", busy, m_busy);
        chk("cmd_ready", cmd_ready, !m_busy);
        chk("done", done, m_done);
        chk("c", c, exp_c);
        chk("q", q, exp_q);
        if (!m_busy) begin
            chk("carry_msb_idle", carry_msb, 1'b0);
            chk("carry_lsb_idle", carry_lsb, 1'b0);
        end
        if (m_busy && m_op == 3'b001) chk("data_in", data_in, m_data);
    endtask

    task automatic step();
        @(posedge clk);
        m_done = 1'b0;
        if (m_busy) begin
            m_t++;
            if (m_t > m_len) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_q    = apply(m_op, m_q0, m_steps, m_fill, m_data);
            end
        end else if (cmd_valid) begin
            m_busy = 1'b1;
            m_t    = 1;
            m_op   = cmd_op;
            m_q0   = m_q;
            m_fill = fill_bit;
            m_data = cmd_data;
            if (cmd_op >= 3'b010 && cmd_op <= 3'b110) m_steps = int'(cmd_amt);
            else if (cmd_op == 3'b001)                m_steps = 1;
            else                                      m_steps = 0;
            m_len = (m_steps == 0) ? 1 : m_steps;
        end
        #1;
        compare();
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] amt, input logic [3:0] data);
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = data;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!m_done && cycles < 20);
        chk("done_timeout", m_done, 1'b1);
    endtask

    initial begin
        int lat;
        model_reset();
        clr       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_amt   = 3'd0;
        cmd_data  = 4'h0;
        fill_bit  = 1'b0;
        #3;
        compare();
        chk("reset_c", c, 2'b00);
        chk("reset_data_in", data_in, 4'h0);
        #4;
        clr = 1'b1;
        step();

        // LOAD 1011
        send(3'b001, 3'd0, 4'b1011);
        wait_done(lat);
        chk("load_lat", lat, 1);
        chk("load_q", q, 4'b1011);

        // ROL 1 then ROR 2 back-to-back
        send(3'b100, 3'd1, 4'h0);
        wait_done(lat);
        chk("rol1_lat", lat, 1);
        chk("rol1_q", q, 4'b0111);
        send(3'b101, 3'd2, 4'h0);
        wait_done(lat);
        chk("ror2_lat", lat, 2);
        chk("ror2_q", q, 4'b1101);

        // ASR and SHR
        send(3'b001, 3'd0, 4'b1000);
        wait_done(lat);
        send(3'b110, 3'd2, 4'h0);
        wait_done(lat);
        chk("asr2_q", q, 4'b1110);
        send(3'b001, 3'd0, 4'b1000);
        wait_done(lat);
        fill_bit = 1'b0;
        send(3'b011, 3'd2, 4'h0);
        wait_done(lat);
        chk("shr2_q", q, 4'b0010);
        fill_bit = 1'b1;
        send(3'b010, 3'd3, 4'h0);
        wait_done(lat);
        chk("shl3_lat", lat, 3);
        chk("shl3_q", q, 4'b0111);
        fill_bit = 1'b0;

        // Zero-length shift and reserved op
        send(3'b001, 3'd0, 4'b0110);
        wait_done(lat);
        send(3'b010, 3'd0, 4'h0);
        wait_done(lat);
        chk("shl0_lat", lat, 1);
        chk("shl0_q", q, 4'b0110);
        send(3'b111, 3'd3, 4'h0);
        wait_done(lat);
        chk("rsvd_lat", lat, 1);
        chk("rsvd_q", q, 4'b0110);

        // ROL by 5 wraps; a command offered while busy is ignored
        send(3'b001, 3'd0, 4'b0001);
        wait_done(lat);
        send(3'b100, 3'd5, 4'h0);
        step();
        cmd_op    = 3'b001;
        cmd_data  = 4'b1111;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        wait_done(lat);
        chk("rol5_rest_lat", lat, 3);
        chk("rol5_q", q, 4'b0010);

        // SHR by 7 saturates to the fill value
        fill_bit = 1'b1;
        send(3'b011, 3'd7, 4'h0);
        wait_done(lat);
        chk("shr7_lat", lat, 7);
        chk("shr7_q", q, 4'b1111);
        fill_bit = 1'b0;

        // Reset in the middle of ROL by 3
        send(3'b100, 3'd3, 4'h0);
        step();
        #3;
        clr = 1'b0;
        #1;
        model_reset();
        compare();
        chk("abort_q", q, 4'b0000);
        chk("abort_c", c, 2'b00);
        chk("abort_busy", busy, 1'b0);
        #1;
        clr = 1'b1;
        step();
        step();

        // Recovers normally after abort
        send(3'b001, 3'd0, 4'b0101);
        wait_done(lat);
        chk("post_abort_q", q, 4'b0101);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
